// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and decodes raw push-buttons.
// Each button passes through a two-flop synchroniser and a per-button
// debounce counter. The block then emits a one-cycle rising-edge pulse per
// button, and a registered single-press decode that strobes press_valid for
// a lone new press or multi_err for simultaneous or chorded presses.
// press_idx is 2 bits wide, so N_BTN must not exceed 4.
module button_conditioner #(
   parameter int unsigned N_BTN           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse,
   output logic             press_valid,
   output logic [1:0]       press_idx,
   output logic             multi_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] s1;
   logic [N_BTN-1:0] s2;
   logic [CNT_W-1:0] cnt     [N_BTN];
   logic [CNT_W-1:0] cnt_nxt [N_BTN];
   logic [N_BTN-1:0] level_nxt;

   logic [N_BTN-1:0] held;
   logic             valid_nxt;
   logic             err_nxt;
   logic [1:0]       idx_nxt;

   // Two-flop synchroniser; nothing else looks at btn_raw
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
      end
   end

   // Debounce: count consecutive cycles of disagreement; any agreement restarts the count
   always_comb begin
      level_nxt = btn_level;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         cnt_nxt[i] = '0;
         if (s2[i] != btn_level[i]) begin
            if (cnt[i] == CNT_MAX) begin
               level_nxt[i] = s2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Debounce state, stable levels and rising-edge pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt[i] <= '0;
         end
         btn_level <= '0;
         btn_pulse <= '0;
      end else begin
         for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
         btn_level <= level_nxt;
         btn_pulse <= level_nxt & ~btn_level;
      end
   end

   // Press decode: a lone pulse with nothing already held is legal; anything else with a pulse is an error
   always_comb begin
      held      = btn_level & ~btn_pulse;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
      idx_nxt   = press_idx;
      if (btn_pulse != '0) begin
         if ($onehot(btn_pulse) && (held == '0)) begin
            valid_nxt = 1'b1;
            for (int unsigned i = 0; i < N_BTN; i++) begin
               if (btn_pulse[i]) begin
                  idx_nxt = 2'(i);
               end
            end
         end else begin
            err_nxt = 1'b1;
         end
      end
   end

   // Registered press event; press_idx holds unless a legal press arrives
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press_valid <= 1'b0;
         press_idx   <= '0;
         multi_err   <= 1'b0;
      end else begin
         press_valid <= valid_nxt;
         press_idx   <= idx_nxt;
         multi_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4.
// Inputs are driven on the falling edge. A new raw value driven while the
// edge count is k is sampled at edge k+1; the pulse then appears at edge k+6
// and press_valid or multi_err at edge k+7.
module tb_button_conditioner;

   localparam int unsigned N_BTN = 4;
   localparam int unsigned DEB   = 4;

   localparam int K_PULSE = 0;
   localparam int K_VALID = 1;
   localparam int K_ERR   = 2;

   typedef struct {
      int unsigned cyc;
      int          kind;
      logic [3:0]  val;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_pulse;
   logic             press_valid;
   logic [1:0]       press_idx;
   logic             multi_err;

   int unsigned cyc;
   int          n_tests;
   int          n_fail;
   exp_t        sb[$];
   int unsigned k;

   button_conditioner #(
      .N_BTN(N_BTN),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .btn_pulse(btn_pulse),
      .press_valid(press_valid),
      .press_idx(press_idx),
      .multi_err(multi_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to timestamp expected and observed events
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int unsigned c, input int kind, input logic [3:0] val);
      exp_t e;
      e.cyc  = c;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
   endtask

   // Expect a press whose raw change is driven now: pulse at +6, strobe at +7
   task automatic expect_press(input logic [3:0] mask, input int kind, input logic [1:0] idx);
      expect_ev(cyc + 6, K_PULSE, mask);
      expect_ev(cyc + 7, kind, {2'b00, idx});
   endtask

   task automatic sb_pop(input int kind, input logic [3:0] val);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_unexpected_event", 32'(sb.size()), 32'(1));
      end else begin
         e = sb.pop_front();
         check("sb_kind", 32'(kind), 32'(e.kind));
         check("sb_edge", 32'(cyc), 32'(e.cyc));
         check("sb_value", 32'(val), 32'(e.val));
      end
   endtask

   task automatic wait_cyc(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every pulse and strobe the DUT produces must match the next scoreboard entry
   initial begin
      forever begin
         @(negedge clk);
         if (btn_pulse != '0) sb_pop(K_PULSE, btn_pulse);
         if (press_valid || multi_err) check("strobe_exclusive", 32'(press_valid & multi_err), 32'(0));
         if (press_valid) sb_pop(K_VALID, {2'b00, press_idx});
         if (multi_err) sb_pop(K_ERR, {2'b00, press_idx});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      btn_raw = '0;
      #1;
      check("rst_level", 32'(btn_level), 32'(0));
      check("rst_pulse", 32'(btn_pulse), 32'(0));
      check("rst_valid", 32'(press_valid), 32'(0));
      check("rst_idx", 32'(press_idx), 32'(0));
      check("rst_err", 32'(multi_err), 32'(0));
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(2);

      // 1: clean press of button 2, held 20 cycles, then released
      btn_raw = 4'b0100;
      expect_press(4'b0100, K_VALID, 2'd2);
      wait_cyc(5);
      check("t1_level_before", 32'(btn_level[2]), 32'(0));
      wait_cyc(1);
      check("t1_level_rise", 32'(btn_level[2]), 32'(1));
      wait_cyc(14);
      btn_raw = 4'b0000;
      wait_cyc(5);
      check("t1_level_held", 32'(btn_level[2]), 32'(1));
      wait_cyc(1);
      check("t1_level_fall", 32'(btn_level[2]), 32'(0));
      check("t1_idx_hold", 32'(press_idx), 32'(2));
      wait_cyc(6);

      // 2: button 1 bounces every 2 cycles for 12 cycles, then settles high
      for (int p = 0; p < 6; p++) begin
         btn_raw[1] = (p % 2 == 0);
         wait_cyc(2);
      end
      check("t2_level_bounce", 32'(btn_level), 32'(0));
      btn_raw[1] = 1'b1;
      expect_press(4'b0010, K_VALID, 2'd1);
      wait_cyc(12);
      check("t2_level_held", 32'(btn_level), 32'(4'b0010));
      btn_raw = 4'b0000;
      wait_cyc(12);

      // 3: three-cycle glitch on button 3 never reaches the stable level
      btn_raw[3] = 1'b1;
      wait_cyc(3);
      btn_raw[3] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         wait_cyc(1);
         check("t3_glitch_level", 32'(btn_level), 32'(0));
      end

      // 4: simultaneous press of buttons 0 and 3; press_idx keeps 1
      btn_raw = 4'b1001;
      expect_press(4'b1001, K_ERR, 2'd1);
      wait_cyc(10);
      check("t4_level", 32'(btn_level), 32'(4'b1001));
      btn_raw = 4'b0000;
      wait_cyc(12);

      // 5: chord - button 0 pressed legally, then button 1 added while 0 is held
      btn_raw = 4'b0001;
      expect_press(4'b0001, K_VALID, 2'd0);
      wait_cyc(10);
      btn_raw = 4'b0011;
      expect_press(4'b0010, K_ERR, 2'd0);
      wait_cyc(10);
      btn_raw = 4'b0000;
      wait_cyc(12);

      // Leave press_idx at 3 so the reset check below observes a real clear
      btn_raw = 4'b1000;
      expect_press(4'b1000, K_VALID, 2'd3);
      wait_cyc(10);
      btn_raw = 4'b0000;
      wait_cyc(12);
      check("t6_idx_pre", 32'(press_idx), 32'(3));

      // 6: reset in the middle of a count on button 2, button kept high
      btn_raw = 4'b0100;
      wait_cyc(4);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_level", 32'(btn_level), 32'(0));
      check("t6_rst_pulse", 32'(btn_pulse), 32'(0));
      check("t6_rst_valid", 32'(press_valid), 32'(0));
      check("t6_rst_idx", 32'(press_idx), 32'(0));
      check("t6_rst_err", 32'(multi_err), 32'(0));
      wait_cyc(2);
      rst = 1'b0;
      k = cyc;
      expect_press(4'b0100, K_VALID, 2'd2);
      wait_cyc(10);
      check("t6_level_after", 32'(btn_level), 32'(4'b0100));

      // 7: asynchronous reset while a stable level is high clears it at once
      #2;
      rst = 1'b1;
      #1;
      check("t7_rst_level", 32'(btn_level), 32'(0));
      check("t7_rst_idx", 32'(press_idx), 32'(0));
      wait_cyc(1);
      btn_raw = 4'b0000;
      wait_cyc(1);
      rst = 1'b0;
      wait_cyc(12);
      check("t7_level_idle", 32'(btn_level), 32'(0));

      check("sb_drained", 32'(sb.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
